// File: rtl/display_bcd_ctrl_pkg.sv
// Shared display types and constants for the binary-to-BCD sequencer.
package display_bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DIGITS    = 4;
    localparam logic [13:0] MAX_VALUE = 14'd9999;
    localparam int          NIBBLE    = 4;

    // Leading-zero mask; the ones digit is never blanked so zero shows "0".
    function automatic logic [3:0] blank_of(input logic [15:0] d);
        logic [3:0] b;
        b[3] = (d[15:12] == 4'd0);
        b[2] = b[3] && (d[11:8] == 4'd0);
        b[1] = b[2] && (d[7:4] == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/display_bcd_ctrl_divide10.sv
// Iterative restoring divide-by-10 of a 14-bit value, one quotient bit per cycle.
// ready drops the cycle after start is sampled and rises when results are valid.
module divide10 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] value,
    output logic [9:0]  quotient,
    output logic [3:0]  remainder,
    output logic        ready
);

    logic [13:0] dvd;
    logic [9:0]  quo;
    logic [3:0]  rem;
    logic [3:0]  cnt;
    logic        rdy;
    logic [4:0]  trial;
    logic [4:0]  diff;
    logic        ge;

    assign trial = {rem, dvd[13]};
    assign ge    = (trial >= 5'd10);
    assign diff  = trial - 5'd10;

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd <= '0;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
            rdy <= 1'b0;
        end else if (start) begin
            dvd <= value;
            quo <= '0;
            rem <= '0;
            cnt <= 4'd14;
            rdy <= 1'b0;
        end else if (cnt != 4'd0) begin
            dvd <= {dvd[12:0], 1'b0};
            quo <= {quo[8:0], ge};
            rem <= ge ? diff[3:0] : trial[3:0];
            cnt <= cnt - 4'd1;
            rdy <= (cnt == 4'd1);
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign ready     = rdy;

endmodule

// File: rtl/display_bcd_ctrl.sv
// Sequences divide10 four times to turn a binary value into display BCD digits.
// Published digits/blank/ovf only move on the edge that enters DONE.
module display_bcd_ctrl #(
    parameter int          DIGITS    = display_bcd_ctrl_pkg::DIGITS,
    parameter logic [13:0] MAX_VALUE = display_bcd_ctrl_pkg::MAX_VALUE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [13:0]                    value,
    input  logic                           convert,
    output logic                           busy,
    output logic                           done,
    output logic [DIGITS*display_bcd_ctrl_pkg::NIBBLE-1:0] digits,
    output logic [DIGITS-1:0]              blank,
    output logic                           ovf
);

    import display_bcd_ctrl_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [13:0] cur;
    logic [1:0]  idx;
    logic [15:0] scratch;
    logic [15:0] merged;
    logic        div_start;
    logic [13:0] div_value;
    logic [9:0]  quotient;
    logic [3:0]  remainder;
    logic        ready;
    logic        accept;
    logic        over;
    logic        last;
    logic        step;

    assign accept = (state == IDLE) && convert;
    assign over   = (value > MAX_VALUE);
    assign last   = (idx == 2'(DIGITS - 1));
    assign step   = (state == WAIT) && ready;

    divide10 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .value     (div_value),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (ready)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (convert) state_nx = over ? DONE : START;
            START: state_nx = WAIT;
            WAIT:  if (ready) state_nx = last ? DONE : START;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        div_start = (state == START);
        div_value = cur;
    end

    // Scratch with the incoming remainder dropped into nibble idx.
    always_comb begin
        merged = scratch;
        unique case (idx)
            2'd0: merged[3:0]   = remainder;
            2'd1: merged[7:4]   = remainder;
            2'd2: merged[11:8]  = remainder;
            2'd3: merged[15:12] = remainder;
            default: merged = scratch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '0;
            idx     <= '0;
            scratch <= '0;
            digits  <= '0;
            blank   <= 4'b1110;
            ovf     <= 1'b0;
        end else begin
            unique case (1'b1)
                accept && over: begin
                    digits <= 16'h9999;
                    blank  <= blank_of(16'h9999);
                    ovf    <= 1'b1;
                end
                accept && !over: begin
                    cur     <= value;
                    idx     <= '0;
                    scratch <= '0;
                end
                step: begin
                    scratch <= merged;
                    cur     <= {4'b0, quotient};
                    if (last) begin
                        digits <= merged;
                        blank  <= blank_of(merged);
                        ovf    <= 1'b0;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/display_bcd_ctrl.md
# display_bcd_ctrl

Sequencer that converts a 14-bit binary value into four BCD digits for the 4-digit seven-segment display by driving the iterative `divide10` unit four times. Each pass feeds the previous quotient back as the next dividend and captures the remainder as the next decimal digit, least significant digit first. The block sits between the value source (counter/switch logic) and the display multiplexer. It holds the last converted digits stable while a new conversion runs.

## Interface
Parameters:
- `DIGITS`, 4: number of decimal digits produced. Fixed at 4 in this design.
- `MAX_VALUE`, 9999: largest value converted without saturating.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  14  binary value to convert; sampled only when a conversion is accepted.
- `convert`  in  1  request; accepted only in IDLE.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  one-cycle pulse when `digits`, `blank` and `ovf` update.
- `digits`  out  16  BCD result. `[3:0]` is the ones digit; `[15:12]` is the thousands digit.
- `blank`  out  4  leading-zero blank mask, one bit per digit. Bit 0 is always 0.
- `ovf`  out  1  last accepted value exceeded `MAX_VALUE`.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE, `convert`=1, `value`≤9999:
  - latch `value` into a 14-bit `cur`;
  - clear digit index `idx` (2 bits) and the scratch digit register;
  - go to START.
- IDLE, `convert`=1, `value`>9999:
  - load `digits`=16'h9999 and `ovf`=1;
  - go to DONE without using the divider.
- START:
  - drive `div_start`=1 and `div_value`=`cur` for exactly one cycle;
  - go to WAIT.
- WAIT:
  - hold until the divider's `ready`=1.
  - Then write `remainder` into scratch nibble `idx`.
  - Load `cur` with `{4'b0, quotient}`.
  - If `idx`=3, go to DONE; otherwise increment `idx` and go to START.
- DONE:
  - copy the scratch register to `digits` (normal path);
  - clear `ovf` (normal path);
  - compute `blank`;
  - pulse `done`;
  - return to IDLE.
- Divider contract:
  - `divide10` samples `start` on an edge and drops `ready` on the following cycle.
  - It raises `ready` when `quotient` and `remainder` are valid.
  - WAIT is entered one cycle after `div_start`, so a stale `ready` is never seen.
- Blank rule:
  - bit 3 is set if digit 3 = 0;
  - bit 2 is set if bit 3 is set and digit 2 = 0;
  - bit 1 is set if bit 2 is set and digit 1 = 0;
  - bit 0 is always 0, so a value of 0 shows "0".
- Width rules:
  - the first quotient is ≤999 and fits in 10 bits;
  - remainders are always 0–9;
  - no truncation occurs for inputs ≤9999.
- `convert` in any state other than IDLE is ignored. It is not queued.
- Outputs change only in DONE. The display never shows partial results.

## Timing
- Reset values:
  - state = IDLE;
  - `busy`=0, `done`=0, `ovf`=0;
  - `digits`=16'h0000, `blank`=4'b1110;
  - `div_start`=0;
  - `cur` and `idx` = 0.
- `rst` is also routed to `divide10`. Reset in any state aborts the conversion, discards partial digits and returns to the reset values on the next edge.
- Let L be the number of cycles from the edge on which the divider samples `start` to the first cycle `ready`=1.
- Each digit takes 1 (START) + L (WAIT) cycles.
- Normal conversion latency:
  - `done` is high 4·(L+1)+1 cycles after the edge that accepted `convert`;
  - `busy` falls on the same edge at which `done` falls.
- Overflow path: `done` is high in the cycle after acceptance.
- `convert` held high continuously: a new conversion is accepted in the first IDLE cycle after DONE, with `value` re-sampled.

## Structure
- Shared display package holds:
  - the state enum (IDLE/START/WAIT/DONE);
  - the constants `DIGITS`=4 and `MAX_VALUE`=14'd9999;
  - the BCD nibble width, 4.
- One sub-module, `divide10`, is instantiated unchanged. Its ports are `clk`, `rst`, `start`, `value[13:0]`, `quotient[9:0]`, `remainder[3:0]` and `ready`.
- The controller itself contains no arithmetic other than `idx` increment and zero compares.

## Test plan
- Directed scenarios:
  - `value`=4934, `convert` pulsed 1 cycle → `digits`=16'h4934, `blank`=0000, `ovf`=0, one `done` pulse at the predicted latency, `busy` high throughout.
  - `value`=7, then `value`=0 → `digits`=16'h0007 with `blank`=1110; then `digits`=16'h0000 with `blank`=1110.
  - `value`=9999, then `value`=10000 → 16'h9999 with `ovf`=0 at full latency; then 16'h9999 with `ovf`=1 and `done` one cycle after acceptance.
  - Start a conversion of 1234, then pulse `convert` with `value`=5678 during WAIT → result is 16'h1234 and only one `done` pulse.
  - Start a conversion of 4321, assert `rst` for one cycle mid-WAIT of digit 2 → all outputs return to reset values. A following conversion of 56 yields 16'h0056 with `blank`=1100.
- Checker: compare every `done` against a software `value`→BCD reference model. Verify `digits` never change except on `done` cycles.
